// File: rtl/div_seq_pkg.sv
// Shared widths, FSM encoding and small arithmetic helpers for the
// multi-cycle integer divide sequencer.
package div_seq_pkg;

    localparam int RegBus        = 32;
    localparam int DoubleRegBus  = 64;
    localparam int DivIterations = 32;

    typedef enum logic [1:0] {
        DivIdle   = 2'd0,
        DivByZero = 2'd1,
        DivRun    = 2'd2,
        DivDone   = 2'd3
    } div_state_e;

    // Two's-complement negation modulo 2^32.
    function automatic logic [RegBus-1:0] neg32(input logic [RegBus-1:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider request/result bundle.
// Handshake: a request is accepted in any cycle where the divider is idle,
// start=1 and annul=0; ready pulses for exactly one cycle with result valid,
// and stall_req stays high from the accept cycle until the cycle before ready.
interface div_seq_if;
    import div_seq_pkg::*;

    logic                    start;
    logic                    signed_div;
    logic [RegBus-1:0]       opdata1;
    logic [RegBus-1:0]       opdata2;
    logic                    annul;
    logic [DoubleRegBus-1:0] result;
    logic                    ready;
    logic                    stall_req;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stall_req
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stall_req
    );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step
    import div_seq_pkg::*;
(
    input  logic [RegBus-1:0] pr_i,
    input  logic              dq_bit_i,
    input  logic [RegBus-1:0] divisor_i,
    output logic [RegBus-1:0] pr_o,
    output logic              q_bit_o
);

    logic [RegBus:0] shifted;
    logic [RegBus:0] trial;

    // The remainder is always below the divisor, so the borrow bit alone
    // tells whether the subtraction went negative.
    assign shifted = {pr_i, dq_bit_i};
    assign trial   = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~trial[RegBus];
    assign pr_o    = q_bit_o ? trial[RegBus-1:0] : shifted[RegBus-1:0];

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: one restoring step per cycle, sign fixup
// on the way into DONE, pipeline stall held while the divide is in flight.
module div_seq
    import div_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    div_seq_if.slave     bus,
    output div_state_e   dbg_state_o
);

    div_state_e              state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [RegBus-1:0]       pr_q, pr_d;
    logic [RegBus-1:0]       dq_q, dq_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic [RegBus-1:0]       quo_q, quo_d;
    logic                    neg_q_q, neg_q_d;
    logic                    neg_r_q, neg_r_d;
    logic [DoubleRegBus-1:0] result_q, result_d;

    logic [RegBus-1:0] step_pr;
    logic              step_q;
    logic [RegBus-1:0] quo_final;
    logic              a_neg, b_neg;

    div_step u_step (
        .pr_i      (pr_q),
        .dq_bit_i  (dq_q[RegBus-1]),
        .divisor_i (divisor_q),
        .pr_o      (step_pr),
        .q_bit_o   (step_q)
    );

    assign quo_final = {quo_q[RegBus-2:0], step_q};
    assign a_neg     = bus.signed_div & bus.opdata1[RegBus-1];
    assign b_neg     = bus.signed_div & bus.opdata2[RegBus-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        dq_d      = dq_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        result_d  = result_q;

        unique case (state_q)
            DivIdle: begin
                if (bus.start && !bus.annul) begin
                    dq_d      = a_neg ? neg32(bus.opdata1) : bus.opdata1;
                    divisor_d = b_neg ? neg32(bus.opdata2) : bus.opdata2;
                    neg_q_d   = a_neg ^ b_neg;
                    neg_r_d   = a_neg;
                    pr_d      = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                    state_d   = (bus.opdata2 == '0) ? DivByZero : DivRun;
                end
            end
            DivByZero: begin
                result_d = '0;
                state_d  = DivDone;
            end
            DivRun: begin
                pr_d  = step_pr;
                dq_d  = {dq_q[RegBus-2:0], 1'b0};
                quo_d = quo_final;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DivIterations - 1)) begin
                    result_d = {neg_r_q ? neg32(step_pr) : step_pr,
                                neg_q_q ? neg32(quo_final) : quo_final};
                    state_d  = DivDone;
                end
            end
            DivDone: begin
                state_d = DivIdle;
            end
            default: begin
                state_d = DivIdle;
            end
        endcase

        // A flush abandons the operation and leaves the last result intact.
        if (bus.annul) begin
            state_d  = DivIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivIdle;
            cnt_q     <= '0;
            pr_q      <= '0;
            dq_q      <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            dq_q      <= dq_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            result_q  <= result_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.ready     = (state_q == DivDone);
    assign bus.stall_req = (state_q == DivIdle && bus.start && !bus.annul) ||
                           (state_q == DivRun) || (state_q == DivByZero);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq: latency, stall window, result values,
// divide-by-zero, overflow corner, flush and reset during RUN.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clk;
  logic rst;
  div_state_e dbg_state;
  div_seq_if dif ();

  int checks;
  int errors;
  logic [63:0] exp_q[$];
  logic [63:0] last_res;

  div_seq dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dif),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one divide, hold start until ready, verify stall window, latency and result.
  task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int lat);
    int got_lat;
    int stall_bad;
    logic [63:0] exp_v;
    exp_q.push_back(exp_res);
    got_lat = -1;
    stall_bad = 0;
    @(negedge clk);
    dif.start = 1'b1;
    dif.signed_div = sd;
    dif.opdata1 = a;
    dif.opdata2 = b;
    #1;
    check({tag, "_stall_T"}, {63'd0, dif.stall_req}, 64'd1);
    for (int cyc = 1; cyc <= 40 && got_lat < 0; cyc++) begin
      @(negedge clk);
      if (dif.ready) begin
        got_lat = cyc;
        if (dif.stall_req) stall_bad++;
        exp_v = exp_q.pop_front();
        check({tag, "_result"}, dif.result, exp_v);
        last_res = exp_v;
        dif.start = 1'b0;
      end else if (!dif.stall_req) begin
        stall_bad++;
      end
    end
    check({tag, "_latency"}, 64'(got_lat), 64'(lat));
    check({tag, "_stall_window"}, 64'(stall_bad), 64'd0);
    dif.start = 1'b0;
  endtask

  // Start a divide and interrupt it at T+10 with annul or rst.
  task automatic run_abort(input string tag, input logic use_rst);
    int ready_seen;
    ready_seen = 0;
    @(negedge clk);
    dif.start = 1'b1;
    dif.signed_div = 1'b0;
    dif.opdata1 = 32'd50;
    dif.opdata2 = 32'd3;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (dif.ready) ready_seen++;
    end
    check({tag, "_run_at_T10"}, 64'(dbg_state), 64'(DivRun));
    if (use_rst) begin
      rst = 1'b1;
      dif.start = 1'b0;
      last_res = 64'd0;
    end else begin
      dif.annul = 1'b1;
    end
    @(negedge clk);
    check({tag, "_idle_T11"}, 64'(dbg_state), 64'(DivIdle));
    check({tag, "_stall_T11"}, {63'd0, dif.stall_req}, 64'd0);
    rst = 1'b0;
    dif.annul = 1'b0;
    dif.start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (dif.ready) ready_seen++;
    end
    check({tag, "_no_ready"}, 64'(ready_seen), 64'd0);
    check({tag, "_result_held"}, dif.result, last_res);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_res = 64'd0;
    rst = 1'b1;
    dif.start = 1'b0;
    dif.signed_div = 1'b0;
    dif.opdata1 = '0;
    dif.opdata2 = '0;
    dif.annul = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'(dbg_state), 64'(DivIdle));
    check("reset_result", dif.result, 64'd0);
    check("reset_ready", {63'd0, dif.ready}, 64'd0);
    check("reset_stall", {63'd0, dif.stall_req}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div("divu_100_7",   1'b0, 32'd100,       32'd7,         {32'h2, 32'hE}, 33);
    run_div("div_m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("div_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,  {32'h1, 32'hFFFFFFFD}, 33);
    run_div("div_by_zero",  1'b0, 32'h1234,      32'd0,         64'd0, 2);
    run_div("div_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000}, 33);
    run_div("divu_max_1",   1'b0, 32'hFFFFFFFF,  32'd1,         {32'h0, 32'hFFFFFFFF}, 33);
    run_div("divu_8000_ff", 1'b0, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000, 32'h0}, 33);
    run_div("btb_9_2",      1'b0, 32'd9,         32'd2,         {32'h1, 32'h4}, 33);
    run_div("btb_9_4",      1'b0, 32'd9,         32'd4,         {32'h1, 32'h2}, 33);

    run_abort("annul", 1'b0);
    run_abort("rst", 1'b1);

    run_div("after_abort",  1'b1, 32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
